// File: rtl/imem_fetch_responder_pkg.sv
// Shared constants and types for the instruction-fetch responder.
// Holds the NOP returned on errors, FSM encoding and the wait-counter width.
package imem_fetch_responder_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Full 30-bit word index is compared so high address bits never alias.
    function automatic logic word_in_range(input logic [29:0] widx, input int depth);
        return {2'b00, widx} < $unsigned(depth);
    endfunction

endpackage

// File: rtl/imem_fetch_responder_imem_array.sv
// Instruction storage: synchronous write, combinational read by word index.
// No reset; a loaded program survives responder reset.
module imem_array #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_dat,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_dat
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/imem_fetch_responder.sv
// Single-outstanding instruction fetch responder; response WAIT_STATES+1 cycles after accept.
// req_ready only in IDLE; response held stable until rsp_ready, then back to IDLE.
module imem_fetch_responder
    import imem_fetch_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_error,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      instr_q, instr_d;
    logic             err_q, err_d;

    logic [31:0] lk_addr;
    logic        lk_err;
    logic        enter_resp;
    logic [31:0] rd_dat;
    logic        unused_ld_bits;

    // With zero wait states the lookup happens on the accept edge itself.
    assign lk_addr        = (state_q == ST_IDLE) ? req_addr : addr_q;
    assign lk_err         = (lk_addr[1:0] != 2'b00) || !word_in_range(lk_addr[31:2], DEPTH);
    assign unused_ld_bits = ^ld_addr[1:0];

    imem_array #(.DEPTH(DEPTH)) u_imem_array (
        .clk    (clk),
        .wr_en  (ld_en && word_in_range(ld_addr[31:2], DEPTH)),
        .wr_idx (ld_addr[AW+1:2]),
        .wr_dat (ld_data),
        .rd_idx (lk_addr[AW+1:2]),
        .rd_dat (rd_dat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    cnt_d  = WAIT_INIT;
                    if (WAIT_INIT != '0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Read-before-write: rd_dat is sampled here before any same-edge load lands.
        instr_d = instr_q;
        err_d   = err_q;
        if (enter_resp) begin
            instr_d = lk_err ? NOP_INSTR : rd_dat;
            err_d   = lk_err;
        end
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_instr = instr_q;
        rsp_addr  = addr_q;
        rsp_error = err_q;
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: directed table, corner sequences and random traffic
// checked against an array-based reference of the instruction memory.
module tb_imem_fetch_responder;

    localparam int          DEPTH = 256;
    localparam int          WS    = 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_error;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;

    imem_fetch_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_error (rsp_error),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] ref_mem [DEPTH];

    typedef struct {
        logic [31:0] addr;
        int          hold;
        logic [31:0] ins;
        logic        err;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en = 1'b0;
        if ((a >> 2) < DEPTH) ref_mem[a >> 2] = d;
    endtask

    function automatic void model(input logic [31:0] a, output logic [31:0] ins, output logic err);
        err = (a % 4 != 0) || ((a / 4) >= DEPTH);
        if (err) ins = NOP;
        else     ins = ref_mem[a / 4];
    endfunction

    task automatic fetch(input logic [31:0] a, input int hold, input logic [31:0] exp_ins,
                         input logic exp_err, input string tag);
        int lat;
        check({tag, " req_ready before"}, 32'(req_ready), 1);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
        req_addr  = ~a;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            check({tag, " req_ready busy"}, 32'(req_ready), 0);
            rsp_ready = 1'b1;
            tick();
            lat++;
        end
        rsp_ready = 1'b0;
        check({tag, " latency"}, lat, WS + 1);
        if (!rsp_valid) return;
        check({tag, " instr"}, rsp_instr, exp_ins);
        check({tag, " error"}, 32'(rsp_error), 32'(exp_err));
        check({tag, " addr"}, rsp_addr, a);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_addr  = $urandom;
            tick();
            check({tag, " hold valid"}, 32'(rsp_valid), 1);
            check({tag, " hold req_ready"}, 32'(req_ready), 0);
            check({tag, " hold instr"}, rsp_instr, exp_ins);
            check({tag, " hold addr"}, rsp_addr, a);
            check({tag, " hold error"}, 32'(rsp_error), 32'(exp_err));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, " valid after hs"}, 32'(rsp_valid), 0);
        check({tag, " req_ready after hs"}, 32'(req_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d, ei;
        logic        ee;

        tick();
        check("reset rsp_valid", 32'(rsp_valid), 0);
        check("reset rsp_instr", rsp_instr, 0);
        check("reset rsp_addr", rsp_addr, 0);
        check("reset rsp_error", 32'(rsp_error), 0);
        reset = 1'b0;
        tick();
        check("post-reset req_ready", 32'(req_ready), 1);
        check("post-reset rsp_valid", 32'(rsp_valid), 0);

        for (int i = 0; i < DEPTH; i++) load(32'(i) << 2, $urandom);
        load(32'h0000_0000, 32'h0050_0093);
        load(32'h0000_0004, 32'h0010_0113);
        load(32'h0000_0008, 32'h0020_0193);
        load(32'h0000_03FC, 32'hCAFE_F00D);
        // Out-of-range loads must not alias onto low words.
        load(32'h0000_0400, 32'hBAD0_BAD0);
        load(32'h4000_0000, 32'hBAD1_BAD1);

        vecs[0]  = '{32'h0000_0000, 0, 32'h0050_0093, 1'b0};
        vecs[1]  = '{32'h0000_0006, 0, NOP,           1'b1};
        vecs[2]  = '{32'h0000_0400, 0, NOP,           1'b1};
        vecs[3]  = '{32'h0000_03FC, 0, 32'hCAFE_F00D, 1'b0};
        vecs[4]  = '{32'h0000_0004, 5, 32'h0010_0113, 1'b0};
        vecs[5]  = '{32'h0000_0001, 1, NOP,           1'b1};
        vecs[6]  = '{32'h0000_0003, 0, NOP,           1'b1};
        vecs[7]  = '{32'h8000_0000, 0, NOP,           1'b1};
        vecs[8]  = '{32'h0001_0000, 0, NOP,           1'b1};
        vecs[9]  = '{32'h0000_0008, 2, 32'h0020_0193, 1'b0};
        vecs[10] = '{32'hFFFF_FFFC, 0, NOP,           1'b1};
        for (int i = 0; i < 11; i++) begin
            fetch(vecs[i].addr, vecs[i].hold, vecs[i].ins, vecs[i].err, $sformatf("vec%0d", i));
        end

        // Reset while waiting drops the request.
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst-wait rsp_valid in reset", 32'(rsp_valid), 0);
        tick();
        reset = 1'b0;
        check("rst-wait req_ready", 32'(req_ready), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst-wait no response", 32'(rsp_valid), 0);
        end
        fetch(32'h0, 0, 32'h0050_0093, 1'b0, "rst-wait refetch");

        // Load to word 2 on the same edge the fetch enters RESP.
        check("raw req_ready", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_addr  = 32'h8;
        tick();
        req_valid = 1'b0;
        ld_en   = 1'b1;
        ld_addr = 32'h8;
        ld_data = 32'hDEAD_BEEF;
        tick();
        ld_en = 1'b0;
        check("raw rsp_valid", 32'(rsp_valid), 1);
        check("raw old data", rsp_instr, 32'h0020_0193);
        ref_mem[2] = 32'hDEAD_BEEF;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        fetch(32'h8, 0, 32'hDEAD_BEEF, 1'b0, "raw refetch");

        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 3) == 0) a = $urandom & 32'hFFFF_FFFC;
                else a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                d = $urandom;
                load(a, d);
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                    1:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                    2:       a = $urandom;
                    default: a = 32'(DEPTH + $urandom_range(0, 3)) << 2;
                endcase
                model(a, ei, ee);
                fetch(a, $urandom_range(0, 3), ei, ee, "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
IMEM_FETCH_RESPONDER -- requirements
Module: imem_fetch_responder

Interface
REQ-001 Parameter DEPTH, default 256, instruction memory size in 32-bit words (power of two, 4..4096).
REQ-002 Parameter WAIT_STATES, default 1, extra cycles between request accept and response (0..15).
REQ-003 Port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  1  fetch request from the PC/next-address logic.
REQ-006 Port req_ready  output  1  responder can accept a request this cycle.
REQ-007 Port req_addr  input  32  byte address of instruction to fetch.
REQ-008 Port rsp_valid  output  1  response holds valid instruction or error.
REQ-009 Port rsp_ready  input  1  consumer accepts response this cycle.
REQ-010 Port rsp_instr  output  32  fetched instruction word.
REQ-011 Port rsp_addr  output  32  echo of the accepted req_addr.
REQ-012 Port rsp_error  output  1  request was misaligned or out of range.
REQ-013 Port ld_en  input  1  program-load write strobe.
REQ-014 Port ld_addr  input  32  program-load byte address (word-aligned, bits [1:0] ignored).
REQ-015 Port ld_data  input  32  program-load word.

Function
REQ-016 FSM states IDLE, WAIT, RESP; exactly one request outstanding; no request queueing.
REQ-017 req_ready = 1 only in IDLE; request accepted on rising edge with req_valid && req_ready.
REQ-018 On accept: latch req_addr into rsp_addr, load wait counter with WAIT_STATES; go to WAIT if WAIT_STATES > 0, else RESP.
REQ-019 WAIT: counter decrements once per cycle; transition to RESP on the edge where counter equals 1.
REQ-020 Latency: rsp_valid asserts exactly WAIT_STATES+1 cycles after the accept edge.
REQ-021 Memory read and error check occur on the edge entering RESP; rsp_instr/rsp_error registered there.
REQ-022 RESP: rsp_valid = 1; rsp_instr, rsp_addr, rsp_error held stable until rsp_valid && rsp_ready.
REQ-023 On response handshake: go to IDLE; rsp_valid deasserts next cycle; next accept no earlier than that cycle.
REQ-024 Misaligned (addr[1:0] != 0): rsp_error = 1, rsp_instr = NOP 32'h00000013.
REQ-025 Out of range (addr[31:2] >= DEPTH): rsp_error = 1, rsp_instr = NOP; both errors take normal latency.
REQ-026 Valid address: rsp_instr = mem[addr[31:2]], rsp_error = 0.
REQ-027 ld_en writes ld_data to mem[ld_addr[31:2]] in any state; out-of-range load addresses are dropped silently.
REQ-028 Load to the word being read on the RESP-entry edge: response returns old data (read-before-write).
REQ-029 req_addr/req_valid changes outside IDLE are ignored; rsp_ready outside RESP is ignored.
REQ-030 Address arithmetic unsigned 32-bit; no wrap, upper bits beyond the index width are checked, not truncated.

Reset
REQ-031 Reset forces IDLE, counter 0, rsp_valid 0, rsp_instr 0, rsp_addr 0, rsp_error 0; req_ready 1 after release.
REQ-032 Reset mid-transaction (WAIT or RESP) drops the request with no response.
REQ-033 Memory contents are not cleared by reset; loaded program survives reset.

Structure
REQ-034 Shared package holds NOP constant 32'h00000013, FSM state encoding, counter width constant.
REQ-035 Storage is one sub-module imem_array (sync write, read addressed by word index); FSM and error check in top.

Verification
REQ-036 Load mem[0]=32'h00500093, WAIT_STATES=1, fetch 0x0 -> rsp_valid 2 cycles after accept, instr 32'h00500093, error 0.
REQ-037 Fetch 0x6 -> rsp_error 1, rsp_instr 32'h00000013, rsp_addr 0x6, same latency.
REQ-038 DEPTH=256, fetch 0x400 -> rsp_error 1, NOP; fetch 0x3FC -> mem[255], error 0.
REQ-039 Hold rsp_ready 0 for 5 cycles in RESP -> outputs stable, req_ready 0 throughout; then handshake -> IDLE.
REQ-040 Assert reset during WAIT -> rsp_valid never asserts; req_ready 1 after release; mem[0] still 32'h00500093.
REQ-041 ld_en to word 2 with 32'hDEADBEEF on RESP-entry edge of fetch 0x8 -> returns prior word; refetch -> 32'hDEADBEEF.
